// File: rtl/ft2232h_pkg.sv
// Shared FT2232H synchronous-FIFO definitions, common to the receive and transmit sides.
package ft2232h_pkg;

    localparam int FT_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OE   = 2'd1,
        READ = 2'd2
    } ft_state_t;

endpackage

// File: rtl/rx_fifo.sv
// Small power-of-two FIFO for received bytes: registered write, combinational head read.
module rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage carries no reset; stale contents are never visible while count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + (PTR_W + 1)'(1);
            end else if (pop && !push) begin
                count <= count - (PTR_W + 1)'(1);
            end
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/ft2232h_rx.sv
// FT2232H synchronous-FIFO receive engine: drives OE#/RD#, buffers captured bytes
// for a valid/ready consumer and counts every byte taken from the device.
module ft2232h_rx
    import ft2232h_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxf_n,
    input  logic [FT_DATA_W-1:0] data_in,
    output logic                 oe_n,
    output logic                 rd_n,
    output logic [FT_DATA_W-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNT_W-1:0]     byte_count
);

    localparam int FIFO_CNT_W = $clog2(DEPTH) + 1;
    localparam logic [FIFO_CNT_W:0] DEPTH_V = (FIFO_CNT_W + 1)'(DEPTH);

    ft_state_t state;
    ft_state_t state_next;

    logic                  push;
    logic                  pop;
    logic                  room;
    logic [FIFO_CNT_W-1:0] count;
    logic [FIFO_CNT_W:0]   count_next;

    assign push       = (state == READ) && !rxf_n;
    assign out_valid  = (count != '0);
    assign pop        = out_valid && out_ready;
    assign count_next = {1'b0, count} + (FIFO_CNT_W + 1)'(push) - (FIFO_CNT_W + 1)'(pop);
    assign room       = (count_next < DEPTH_V);

    // Room is judged on the occupancy after this edge, so a full buffer that is
    // draining in the same cycle still lets RD# stay low.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!rxf_n && room) begin
                    state_next = OE;
                end
            end
            OE: begin
                if (rxf_n) begin
                    state_next = IDLE;
                end else if (room) begin
                    state_next = READ;
                end
            end
            READ: begin
                if (rxf_n) begin
                    state_next = IDLE;
                end else if (!room) begin
                    state_next = OE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Strobes are registered copies of the next-state decode, so they always
    // agree with the state register and never see input glitches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            oe_n  <= 1'b1;
            rd_n  <= 1'b1;
        end else begin
            state <= state_next;
            oe_n  <= (state_next == IDLE);
            rd_n  <= (state_next != READ);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_count <= '0;
        end else if (push) begin
            byte_count <= byte_count + CNT_W'(1);
        end
    end

    rx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FT_DATA_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (data_in),
        .pop   (pop),
        .dout  (out_data),
        .count (count)
    );

endmodule

// File: doc/ft2232h_rx.md
FT2232H_RX -- requirements
Module: ft2232h_rx

Interface
REQ-001 The parameters SHALL be:
- DEPTH, default 4, power of two >= 2: entries in the internal receive buffer.
- CNT_W, default 16: width of the received-byte counter.

REQ-002 The ports SHALL be (name, direction, width, meaning):
- clk, in, 1: single clock, the FT2232H 60 MHz CLKOUT; all logic is on its rising edge.
- reset, in, 1: asynchronous, active-high reset.
- rxf_n, in, 1: FT2232H RXF#; low means the device holds unread data.
- data_in, in, 8: FT2232H data bus (ADBUS) while OE# is low.
- oe_n, out, 1: FT2232H OE#, registered, active low.
- rd_n, out, 1: FT2232H RD#, registered, active low.
- out_data, out, 8: head byte of the receive buffer.
- out_valid, out, 1: the buffer is non-empty.
- out_ready, in, 1: downstream accepts out_data.
- byte_count, out, CNT_W: total bytes captured, wraps modulo 2^CNT_W.

Function
REQ-003 The block SHALL implement the FT2232H synchronous-FIFO read protocol with a three-state FSM: IDLE, OE, READ.
REQ-004 The outputs per state SHALL be:
- IDLE: oe_n=1, rd_n=1.
- OE: oe_n=0, rd_n=1.
- READ: oe_n=0, rd_n=0.
oe_n and rd_n SHALL be driven from registers only, with no combinational path from inputs.
REQ-005 From IDLE, the FSM SHALL go to OE when rxf_n==0 and count_next<DEPTH; otherwise it stays in IDLE.
REQ-006 From OE, the FSM SHALL go to READ when rxf_n==0 and count_next<DEPTH, and SHALL go to IDLE when rxf_n==1; otherwise it stays in OE. OE is always at least one cycle before RD# falls.
REQ-007 A byte push (capture) SHALL occur on a rising edge if and only if state==READ and rxf_n==0; data_in is written to the buffer and byte_count increments.
REQ-008 From READ, the FSM SHALL stay in READ iff rxf_n==0 and count_next<DEPTH. It goes to IDLE if rxf_n==1, and to OE if rxf_n==0 and count_next==DEPTH.
REQ-009 count_next SHALL equal count + push - pop for the current cycle, where pop = out_valid & out_ready.
REQ-010 No byte SHALL be captured while rd_n==1 or rxf_n==1, and a byte seen with rxf_n==1 SHALL never be stored.
REQ-011 The buffer SHALL be first-in first-out, with the following boundary behaviour:
- out_data shows the oldest entry whenever out_valid==1.
- out_valid is low when count==0.
- Pointers wrap modulo DEPTH.
- A push and pop in the same cycle leave count unchanged and are both legal, including at count==DEPTH.
- A push when count==DEPTH without a pop SHALL never occur, by construction of REQ-005/006/008.
REQ-012 Back-to-back reads SHALL sustain one byte per clock while rxf_n==0 and the consumer holds out_ready==1.
REQ-013 Latency from capture edge to out_valid==1 SHALL be one clock (registered buffer write, combinational head read).
REQ-014 out_data and out_valid SHALL be stable while out_valid==1 and out_ready==0.
REQ-015 byte_count SHALL wrap from 2^CNT_W-1 to 0 without any other effect.

Reset
REQ-016 Asserting reset SHALL immediately, without waiting for clk, force the following values: state=IDLE, oe_n=1, rd_n=1, count=0, read and write pointers=0, out_valid=0, byte_count=0.
REQ-017 Reset asserted during READ SHALL discard buffered bytes and release RD#/OE# within the same cycle.
REQ-018 After reset deasserts, the first possible rd_n=0 SHALL be no earlier than the second rising edge after OE is entered.
REQ-019 Buffer storage contents SHALL be don't-care after reset.

Structure
REQ-020 A shared package ft2232h_pkg SHALL hold the FSM state type (IDLE/OE/READ) and the constant FT_DATA_W=8, for reuse by the transmit side.
REQ-021 The receive buffer SHALL be a sub-module rx_fifo with the following properties:
- Parameters: DEPTH and width.
- Ports: push, din, pop, dout, count.
- The FSM and byte counter stay in ft2232h_rx.

Verification
REQ-022 Single byte: from reset, hold rxf_n=0 for the minimum burst and present data_in=8'hA5 during READ, with out_ready=1. Required response:
- oe_n falls one cycle before rd_n.
- Exactly one byte 8'hA5 appears on out_data.
- byte_count=1.
REQ-023 Burst: rxf_n=0 for 10 READ cycles with data_in incrementing from 8'h00 and out_ready=1. Required response:
- 10 bytes 00..09 delivered in order at one per clock.
- rd_n low for exactly 10 consecutive cycles.
REQ-024 Backpressure: out_ready=0, rxf_n=0 continuously with DEPTH=4. Required response:
- Exactly 4 bytes captured, then FSM in OE with rd_n=1.
- Raising out_ready resumes reading with no loss or duplication.
REQ-025 RXF# drop: rxf_n rises mid-burst after 3 bytes. Required response:
- rd_n rises on the next edge.
- The byte present while rxf_n==1 is not stored.
- byte_count=3.
REQ-026 Reset mid-READ: assert reset asynchronously with 2 bytes buffered. Required response:
- oe_n=1, rd_n=1, out_valid=0 and byte_count=0 before the next clk edge.
REQ-027 Wrap: with CNT_W=4, deliver 17 bytes. Required response: byte_count=1 and data order preserved across pointer wrap.
